pe_shift_mac: RTL and testbench
===============================

// Module: pe_shift_mac
// PURPOSE
//  Weight-stationary systolic PE, second generation. Multiplies an unsigned activation by a log-quantised
//  weight (sign + power-of-two exponent) using a barrel shifter, then adds the product to an incoming partial sum.
//  Adds a double-buffered weight (shadow/active), valid tracking, a global stall and activation/weight forwarding.
//  Tiles into an array: act passes east, weight passes south through the chain, psum passes south.
// PARAMETERS
//  ACT_W  8   activation width, unsigned
//  WGT_W  4   weight code width; MSB = sign, low WGT_W-1 bits = exponent
//  ACC_W  21  partial-sum width, signed two's complement
//  SH_W   15  barrel-shifter output width; must equal ACT_W + 2**(WGT_W-1) - 1
// PORTS
//  clk          in   1      clock, rising edge
//  rst_n        in   1      synchronous active-low reset
//  en           in   1      global enable; 0 = full-pipeline stall
//  weight_load  in   1      capture weight_in into shadow register
//  weight_in    in   WGT_W  weight code from the north neighbour
//  weight_swap  in   1      copy shadow into active weight
//  act_valid    in   1      act_in / psum_in valid
//  act_in       in   ACT_W  activation from the west
//  psum_in      in   ACC_W  partial sum from the north
//  act_out      out  ACT_W  activation to the east, 1-cycle delay
//  act_valid_o  out  1      act_valid to the east, 1-cycle delay
//  out_weight   out  WGT_W  shadow weight forwarded south, 1-cycle delay
//  psum_out     out  ACC_W  accumulated partial sum
//  psum_valid   out  1      psum_out valid
//  ovf          out  1      overflow on the current psum_out (sticky only under PE_SAT_EN)
// BEHAVIOUR
//  Reset: all registers clear on a rising clk edge with rst_n=0.
//   - Outputs reset to 0.
//   - Shadow and active weights reset to 4'b1000, the zero code.
//   - Reset overrides en.
//   - Mid-operation reset discards in-flight data; psum_valid is 0 on the next cycle.
//  Weight code w: sign s = w[WGT_W-1], exponent e = w[WGT_W-2:0].
//   - The code with s=1, e=0 means zero: product = 0.
//   - Otherwise product = (s ? -1 : +1) * (act << e).
//  Stall: while en=0 every register, including shadow/active weight, holds its value. Loads and swaps are ignored.
//  Weight path, when en=1:
//   - weight_load=1 -> shadow <= weight_in, and out_weight <= weight_in in the same cycle.
//   - weight_swap=1 -> active <= shadow, using the pre-edge shadow value.
//   - Load and swap in the same cycle: active gets the OLD shadow and shadow gets the new weight_in.
//  Pipeline, 2 cycles, valid-qualified:
//   - Stage 1 (cycle N+1): sh = act_in << e, zero-extended to SH_W. Register sh, sign, zero flag and
//     psum_in, using the active weight at cycle N.
//   - Stage 2 (cycle N+2): psum_out = psum_r +/- sh, computed at ACC_W+1 bits. psum_valid = stage-1 valid.
//   - A weight_swap at or after cycle N does not affect a sample captured at cycle N.
//   - act_valid=0: stage valids clear and psum_out holds its last value.
//  Forwarding: act_out/act_valid_o register act_in/act_valid every enabled cycle.
//  Arithmetic: sh is always positive, so the ACC_W+1 sum has a meaningful carry. Overflow means the
//  top two bits of the sum differ.
// CONFIGURATION
//  PE_SAT_EN defined:
//   - On overflow, psum_out clamps to +(2**(ACC_W-1)-1) or -(2**(ACC_W-1)).
//   - ovf is sticky until reset.
//  PE_SAT_EN undefined:
//   - psum_out wraps modulo 2**ACC_W.
//   - ovf is a 1-cycle flag aligned with psum_valid.
// TESTING
//  T1 load+swap 4'b0010; act=4, psum_in=1, valid -> psum_out=17, psum_valid high 2 cycles later.
//  T2 weight 4'b1011; act=3, psum_in=100 -> psum_out=76.
//  T3 zero code 4'b1000; act=255, psum_in=-5 -> psum_out=-5.
//  T4 same-cycle load 4'b0001 + swap after active=+4 -> sample at that cycle uses +4; next sample uses the old shadow.
//     out_weight shows 4'b0001 one cycle later.
//  T5 en=0 for 3 cycles mid-stream -> all outputs frozen; results resume in order, none lost or duplicated.
//  T6 weight 4'b0111, act=255, psum_in=1048575:
//     PE_SAT_EN -> psum_out=1048575, ovf=1.
//     Without PE_SAT_EN -> psum_out=-1015937, ovf pulses.

Source files
------------

// File: rtl/pe_shift_mac_if.sv
// pe_shift_mac_if: data/control bundle for one shift-MAC processing element.
//   master: drives en, weight_load/weight_in/weight_swap, act_valid/act_in, psum_in
//           (the west/north neighbours, or a bench)
//   slave : the PE itself; returns act_out/act_valid_o (east), out_weight and
//           psum_out/psum_valid/ovf (south)
interface pe_shift_mac_if #(
  parameter int ACT_W = 8,
  parameter int WGT_W = 4,
  parameter int ACC_W = 21
);
  logic             en;
  logic             weight_load;
  logic [WGT_W-1:0] weight_in;
  logic             weight_swap;
  logic             act_valid;
  logic [ACT_W-1:0] act_in;
  logic [ACC_W-1:0] psum_in;
  logic [ACT_W-1:0] act_out;
  logic             act_valid_o;
  logic [WGT_W-1:0] out_weight;
  logic [ACC_W-1:0] psum_out;
  logic             psum_valid;
  logic             ovf;

  modport master (
    output en, weight_load, weight_in, weight_swap, act_valid, act_in, psum_in,
    input  act_out, act_valid_o, out_weight, psum_out, psum_valid, ovf
  );

  modport slave (
    input  en, weight_load, weight_in, weight_swap, act_valid, act_in, psum_in,
    output act_out, act_valid_o, out_weight, psum_out, psum_valid, ovf
  );
endinterface

// File: rtl/pe_shift_mac.sv
// pe_shift_mac: weight-stationary systolic PE with a log-quantised weight.
//   product = (sign ? -1 : +1) * (act << exp); code {1, 0...0} is zero.
//   psum_out = psum_in + product, two register stages after the sample.
//   Double-buffered weight (shadow/active), global stall (en), east/south forwarding.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    pe_shift_mac_if.slave (see interface header)
// Build option:
//   PE_SAT_EN  defined   -> psum_out saturates on overflow, ovf sticky until reset
//              undefined -> psum_out wraps, ovf is a one-cycle flag with psum_valid
module pe_shift_mac #(
  parameter int ACT_W = 8,
  parameter int WGT_W = 4,
  parameter int ACC_W = 21,
  parameter int SH_W  = ACT_W + 2**(WGT_W-1) - 1
) (
  input  logic           clk,
  input  logic           rst_n,
  pe_shift_mac_if.slave  bus
);
  localparam int STAGES = 2;
  localparam logic [WGT_W-1:0] W_ZERO = {1'b1, {(WGT_W-1){1'b0}}};

  typedef struct packed {
    logic [SH_W-1:0]  sh;
    logic             neg;
    logic             zero;
    logic [ACC_W-1:0] psum;
  } s1_t;

  logic [WGT_W-1:0] shadow_w, active_w;
  logic [STAGES:1]  vld_pipe;   // [1] = stage-1 valid (also act_valid_o), [2] = psum_valid
  s1_t              s1_q, s1_d;
  logic [ACT_W-1:0] act_q;
  logic [WGT_W-1:0] out_w_q;
  logic [ACC_W-1:0] psum_q;
  logic             ovf_q;

  // Stage-1 combinational: barrel shift on the active weight as of this cycle
  always_comb begin
    s1_d      = '0;
    s1_d.sh   = {{(SH_W-ACT_W){1'b0}}, bus.act_in} << active_w[WGT_W-2:0];
    s1_d.neg  = active_w[WGT_W-1];
    s1_d.zero = (active_w == W_ZERO);
    s1_d.psum = bus.psum_in;
  end

  // Stage-2 combinational: one extra bit so the carry out of a positive add is kept
  logic [ACC_W:0]   psum_x, sh_x, sum;
  logic             ov;
  logic [ACC_W-1:0] res;

  always_comb begin
    psum_x = {s1_q.psum[ACC_W-1], s1_q.psum};
    sh_x   = {{(ACC_W+1-SH_W){1'b0}}, s1_q.sh};
    if (s1_q.zero)     sum = psum_x;
    else if (s1_q.neg) sum = psum_x - sh_x;
    else               sum = psum_x + sh_x;
    ov = sum[ACC_W] ^ sum[ACC_W-1];
`ifdef PE_SAT_EN
    // Clamp toward the true sign, held in the extra top bit
    if (ov) res = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else    res = sum[ACC_W-1:0];
`else
    res = sum[ACC_W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_w <= W_ZERO;
      active_w <= W_ZERO;
      vld_pipe <= '0;
      s1_q     <= '0;
      act_q    <= '0;
      out_w_q  <= '0;
      psum_q   <= '0;
      ovf_q    <= 1'b0;
    end else if (bus.en) begin
      // Swap reads the pre-edge shadow, so load+swap moves the old shadow to active
      if (bus.weight_load) begin
        shadow_w <= bus.weight_in;
        out_w_q  <= bus.weight_in;
      end
      if (bus.weight_swap) active_w <= shadow_w;

      vld_pipe <= {vld_pipe[STAGES-1:1], bus.act_valid};
      act_q    <= bus.act_in;
      if (bus.act_valid) s1_q <= s1_d;

      // psum_out holds across bubbles; ovf tracks only valid results
      if (vld_pipe[1]) psum_q <= res;
`ifdef PE_SAT_EN
      ovf_q <= ovf_q | (vld_pipe[1] & ov);
`else
      ovf_q <= vld_pipe[1] & ov;
`endif
    end
  end

  assign bus.act_out     = act_q;
  assign bus.act_valid_o = vld_pipe[1];
  assign bus.out_weight  = out_w_q;
  assign bus.psum_out    = psum_q;
  assign bus.psum_valid  = vld_pipe[STAGES];
  assign bus.ovf         = ovf_q;
endmodule

// File: tb/tb_pe_shift_mac.sv
module tb_pe_shift_mac;
  localparam int ACT_W = 8, WGT_W = 4, ACC_W = 21;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pe_shift_mac_if #(.ACT_W(ACT_W), .WGT_W(WGT_W), .ACC_W(ACC_W)) bus();
  pe_shift_mac #(.ACT_W(ACT_W), .WGT_W(WGT_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct { longint psum; longint ovf; string tag; } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;

  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(longint p, longint o, string t);
    exp_t e;
    e.psum = p; e.ovf = o; e.tag = t;
    sb.push_back(e);
  endtask

  task automatic step(bit ld, logic [WGT_W-1:0] w, bit sw, bit v, logic [ACT_W-1:0] a, longint p);
    bus.weight_load = ld;
    bus.weight_in   = w;
    bus.weight_swap = sw;
    bus.act_valid   = v;
    bus.act_in      = a;
    bus.psum_in     = p[ACC_W-1:0];
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(0, '0, 0, 0, '0, 0);
  endtask

  // Monitor: a result is new only after an edge taken with en=1 and out of reset
  initial begin
    bit en_s, rst_s;
    exp_t e;
    forever begin
      @(posedge clk);
      en_s  = bus.en;
      rst_s = rst_n;
      @(negedge clk);
      if (rst_s && en_s && bus.psum_valid) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_psum_valid: got psum_out=%0d with nothing expected", $signed(bus.psum_out));
        end else begin
          e = sb.pop_front();
          chk({e.tag, ".psum"}, $signed(bus.psum_out), e.psum);
          chk({e.tag, ".ovf"}, bus.ovf, e.ovf);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.en = 1'b1;
    bus.weight_load = 0; bus.weight_in = '0; bus.weight_swap = 0;
    bus.act_valid = 0; bus.act_in = '0; bus.psum_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.psum_out", bus.psum_out, 0);
    chk("rst.psum_valid", bus.psum_valid, 0);
    chk("rst.ovf", bus.ovf, 0);
    chk("rst.act_out", bus.act_out, 0);
    chk("rst.act_valid_o", bus.act_valid_o, 0);
    chk("rst.out_weight", bus.out_weight, 0);
    rst_n = 1'b1;

    // Active weight comes out of reset as the zero code
    step(0, '0, 0, 1, 8'd255, 7); push(7, 0, "rst_zero_wgt");
    chk("fwd.act_out", bus.act_out, 255);
    chk("fwd.act_valid_o", bus.act_valid_o, 1);
    idle();

    // T1: +4, act 4, psum 1 -> 17, two-cycle latency
    step(1, 4'b0010, 0, 0, '0, 0);
    chk("t1.out_weight", bus.out_weight, 2);
    step(0, '0, 1, 0, '0, 0);
    step(0, '0, 0, 1, 8'd4, 1); push(17, 0, "t1");
    chk("t1.lat1_valid", bus.psum_valid, 0);
    idle();
    chk("t1.lat2_valid", bus.psum_valid, 1);
    idle();

    // T2: -8, act 3, psum 100 -> 76
    step(1, 4'b1011, 0, 0, '0, 0);
    step(0, '0, 1, 0, '0, 0);
    step(0, '0, 0, 1, 8'd3, 100); push(76, 0, "t2");
    idle(); idle();

    // T3: zero code
    step(1, 4'b1000, 0, 0, '0, 0);
    step(0, '0, 1, 0, '0, 0);
    step(0, '0, 0, 1, 8'd255, -5); push(-5, 0, "t3");
    idle(); idle();

    // T4: active +4, shadow +8; then load 0001 + swap + sample together
    step(1, 4'b0010, 0, 0, '0, 0);
    step(0, '0, 1, 0, '0, 0);
    step(1, 4'b0011, 0, 0, '0, 0);
    step(1, 4'b0001, 1, 1, 8'd5, 0); push(20, 0, "t4_same_cycle");
    chk("t4.out_weight", bus.out_weight, 1);
    step(0, '0, 0, 1, 8'd5, 0); push(40, 0, "t4_old_shadow");
    step(0, '0, 1, 0, '0, 0);
    step(0, '0, 0, 1, 8'd5, 0); push(10, 0, "t4_new_shadow");
    idle(); idle();

    // T5: weight +2 active; stall 3 cycles with garbage on every input
    step(0, '0, 0, 1, 8'd1, 100); push(102, 0, "t5_s1");
    step(0, '0, 0, 1, 8'd2, 200); push(204, 0, "t5_s2");
    step(0, '0, 0, 1, 8'd3, 300); push(306, 0, "t5_s3");
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1, 4'b0111, 1, 1, 8'hAA, 12345);
      chk("t5.stall_psum_out", $signed(bus.psum_out), 204);
      chk("t5.stall_psum_valid", bus.psum_valid, 1);
      chk("t5.stall_act_out", bus.act_out, 3);
      chk("t5.stall_out_weight", bus.out_weight, 1);
    end
    bus.en = 1'b1;
    step(0, '0, 0, 1, 8'd4, 400); push(408, 0, "t5_s4");
    step(0, '0, 0, 1, 8'd5, 500); push(510, 0, "t5_s5");
    step(0, '0, 0, 1, 8'd6, 600); push(612, 0, "t5_s6");
    idle(); idle();

    // T6: +128, 255*128 + 1048575 overflows; follow-up shows sticky vs pulse
    step(1, 4'b0111, 0, 0, '0, 0);
    step(0, '0, 1, 0, '0, 0);
`ifdef PE_SAT_EN
    step(0, '0, 0, 1, 8'd255, 1048575); push(1048575, 1, "t6_ovf");
    step(0, '0, 0, 1, 8'd1, 0); push(128, 1, "t6_after");
`else
    step(0, '0, 0, 1, 8'd255, 1048575); push(-1015937, 1, "t6_ovf");
    step(0, '0, 0, 1, 8'd1, 0); push(128, 0, "t6_after");
`endif
    idle(); idle();

    // Mid-operation reset drops the in-flight sample and the weights
    step(0, '0, 0, 1, 8'd9, 50);
    rst_n = 1'b0;
    idle();
    chk("midrst.psum_valid", bus.psum_valid, 0);
    chk("midrst.psum_out", bus.psum_out, 0);
    chk("midrst.ovf", bus.ovf, 0);
    rst_n = 1'b1;
    step(0, '0, 0, 1, 8'd9, 3); push(3, 0, "post_rst_zero_wgt");
    idle(); idle();

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    chk("drain.pending", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
